com_tracker: RTL

COM_TRACKER -- requirements
Module: com_tracker

---
 rtl/com_tracker.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/com_tracker.sv
// com_tracker: single-target centroid tracker.
//
// Smooths raw centroid samples with a first-order IIR filter held in
// fixed point (ALPHA_SHIFT fraction bits). Samples far from the current
// estimate snap the filter instead of dragging it. Lock is kept while
// frames keep delivering samples. It is dropped after LOST_FRAMES
// consecutive empty frames.
//
// Ports:
//   clk_in      system clock, rising edge
//   rst_in      synchronous active-high reset
//   x_in/y_in   raw centroid (11 / 10 bits), qualified by valid_in
//   valid_in    single-cycle sample strobe
//   frame_in    single-cycle end-of-frame pulse
//   x_out/y_out filtered position, integer part
//   valid_out   one-cycle pulse, x_out/y_out just updated
//   locked_out  high while tracking or coasting
module com_tracker #(
  parameter int ALPHA_SHIFT = 2,
  parameter int LOST_FRAMES = 8,
  parameter int JUMP_THRESH = 128
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic        valid_in,
  input  logic        frame_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        valid_out,
  output logic        locked_out
);

  localparam int AX_W = 11 + ALPHA_SHIFT;
  localparam int AY_W = 10 + ALPHA_SHIFT;
  localparam logic [12:0] JUMP = 13'(JUMP_THRESH);
  localparam logic [7:0]  LOST = 8'(LOST_FRAMES);

  typedef enum logic [1:0] {EMPTY, TRACKING, COASTING} state_t;

  state_t          state_reg, state_next;
  logic [AX_W-1:0] acc_x_reg, acc_x_next;
  logic [AY_W-1:0] acc_y_reg, acc_y_next;
  logic [7:0]      miss_reg, miss_next;
  logic            seen_reg, seen_next;
  logic [10:0]     x_next;
  logic [9:0]      y_next;
  logic            valid_next;

  // Per-axis distance between the new sample and the current output.
  logic signed [12:0] dist_x, dist_y;
  logic [12:0]        abs_x, abs_y;
  logic               jump;

  assign dist_x = $signed({2'b00, x_in}) - $signed({2'b00, x_out});
  assign dist_y = $signed({3'b000, y_in}) - $signed({3'b000, y_out});
  assign abs_x  = dist_x[12] ? 13'(-dist_x) : 13'(dist_x);
  assign abs_y  = dist_y[12] ? 13'(-dist_y) : 13'(dist_y);
  assign jump   = (abs_x > JUMP) || (abs_y > JUMP);

  // Signed error with one guard bit; the arithmetic shift floors toward
  // minus infinity, so the estimate converges without overshoot.
  logic signed [AX_W:0] diff_x;
  logic signed [AY_W:0] diff_y;

  assign diff_x = $signed({1'b0, x_in, {ALPHA_SHIFT{1'b0}}}) - $signed({1'b0, acc_x_reg});
  assign diff_y = $signed({1'b0, y_in, {ALPHA_SHIFT{1'b0}}}) - $signed({1'b0, acc_y_reg});

  always_comb begin
    state_next = state_reg;
    acc_x_next = acc_x_reg;
    acc_y_next = acc_y_reg;
    miss_next  = miss_reg;
    seen_next  = seen_reg;
    x_next     = x_out;
    y_next     = y_out;
    valid_next = 1'b0;

    if (valid_in) begin
      seen_next  = 1'b1;
      valid_next = 1'b1;
      if (state_reg == EMPTY || jump) begin
        acc_x_next = {x_in, {ALPHA_SHIFT{1'b0}}};
        acc_y_next = {y_in, {ALPHA_SHIFT{1'b0}}};
      end else begin
        // The result always lies between the old estimate and the sample,
        // so truncating back to accumulator width cannot wrap.
        acc_x_next = AX_W'($signed({1'b0, acc_x_reg}) + (diff_x >>> ALPHA_SHIFT));
        acc_y_next = AY_W'($signed({1'b0, acc_y_reg}) + (diff_y >>> ALPHA_SHIFT));
      end
      if (state_reg == EMPTY) begin
        state_next = TRACKING;
      end
      x_next = acc_x_next[AX_W-1:ALPHA_SHIFT];
      y_next = acc_y_next[AY_W-1:ALPHA_SHIFT];
    end

    if (frame_in) begin
      seen_next = 1'b0;
      if (state_reg != EMPTY) begin
        // A sample arriving with the frame pulse makes the frame non-empty.
        if (seen_reg || valid_in) begin
          miss_next  = 8'd0;
          state_next = TRACKING;
        end else if (miss_reg + 8'd1 == LOST) begin
          miss_next  = 8'd0;
          state_next = EMPTY;
        end else begin
          miss_next  = miss_reg + 8'd1;
          state_next = COASTING;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg <= EMPTY;
      acc_x_reg <= '0;
      acc_y_reg <= '0;
      miss_reg  <= '0;
      seen_reg  <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      valid_out <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_x_reg <= acc_x_next;
      acc_y_reg <= acc_y_next;
      miss_reg  <= miss_next;
      seen_reg  <= seen_next;
      x_out     <= x_next;
      y_out     <= y_next;
      valid_out <= valid_next;
    end
  end

  assign locked_out = (state_reg != EMPTY);

endmodule
